// File: rtl/aeolus_alu_pkg.sv
// aeolus_alu_pkg
// Shared constants and types for the Aeolus ALU datapath.
//   IN_WIDTH_DEF  : default operand width of the A/B registers
//   OUT_WIDTH_DEF : default width of the ALU result, shifter input and accumulator
//   alu_op_e      : operation selected by the strobe priority encoder
package aeolus_alu_pkg;

    localparam int IN_WIDTH_DEF  = 4;
    localparam int OUT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_INV  = 3'd6,
        OP_CLR  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/aeolus_alu_datapath_alu_core.sv
// alu_core
// Purely combinational arithmetic/logic function of the Aeolus datapath.
// Ports:
//   in1, in2 : W-bit operands
//   op       : operation (alu_op_e)
//   result   : W-bit result, modulo 2^W
//   carry    : carry out of bit W-1 for OP_ADD, borrow (in1 < in2) for OP_SUB,
//              0 for every other operation
module alu_core
    import aeolus_alu_pkg::*;
#(
    parameter int W = OUT_WIDTH_DEF
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  alu_op_e      op,
    output logic [W-1:0] result,
    output logic         carry
);

    logic [W:0] sum;

    assign sum = {1'b0, in1} + {1'b0, in2};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[W-1:0];
                carry  = sum[W];
            end
            OP_SUB: begin
                result = in1 - in2;
                carry  = (in1 < in2);
            end
            OP_AND:  result = in1 & in2;
            OP_OR:   result = in1 | in2;
            OP_XOR:  result = in1 ^ in2;
            OP_INV:  result = ~in1;
            OP_CLR:  result = '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/aeolus_alu_datapath.sv
// aeolus_alu_datapath
// Accumulator datapath: strobe decode, operand select, one alu_core and the
// accumulator / overflow registers.
// Build option: define AEOLUS_ALU_OVF_EN to register the overflow flag;
// without it ovf is constant 0 and no overflow register exists.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   add..snzs           : decoded instruction strobes (normally one-hot)
//   sf                  : shifter flag, qualifies snza / snzs
//   a_in, b_in          : IN_WIDTH register values
//   shift_in            : OUT_WIDTH shifter output
//   acc_out             : accumulator
//   alu_out             : combinational ALU result
//   ovf                 : registered carry/borrow flag
module aeolus_alu_datapath
    import aeolus_alu_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 add,
    input  logic                 sub,
    input  logic                 and_op,
    input  logic                 or_op,
    input  logic                 xor_op,
    input  logic                 inv,
    input  logic                 clr,
    input  logic                 snza,
    input  logic                 snzs,
    input  logic                 sf,
    input  logic [IN_WIDTH-1:0]  a_in,
    input  logic [IN_WIDTH-1:0]  b_in,
    input  logic [OUT_WIDTH-1:0] shift_in,
    output logic [OUT_WIDTH-1:0] acc_out,
    output logic [OUT_WIDTH-1:0] alu_out,
    output logic                 ovf
);

    logic                 sel_shift;
    logic                 sel_a;
    logic                 add_eff;
    logic                 acc_en;
    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH-1:0] in1;
    logic [OUT_WIDTH-1:0] in2;
    logic                 alu_carry;
    alu_op_e              op;

    assign a_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, a_in};
    assign b_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, b_in};

    // snz* only take effect when the shifter flag is set
    assign sel_shift = snzs & sf;
    assign sel_a     = snza & sf;
    assign add_eff   = add | sel_a | sel_shift;
    assign acc_en    = clr | add_eff | sub | and_op | or_op | xor_op | inv;

    // snzs wins over snza if both qualify
    always_comb begin
        in1 = a_ext;
        in2 = b_ext;
        if (sel_shift) begin
            in1 = acc_out;
            in2 = shift_in;
        end else if (sel_a) begin
            in1 = acc_out;
            in2 = a_ext;
        end
    end

    // Priority encoder: clr > add_eff > sub > and > or > xor > inv
    always_comb begin
        op = OP_NONE;
        if (clr)         op = OP_CLR;
        else if (add_eff) op = OP_ADD;
        else if (sub)    op = OP_SUB;
        else if (and_op) op = OP_AND;
        else if (or_op)  op = OP_OR;
        else if (xor_op) op = OP_XOR;
        else if (inv)    op = OP_INV;
    end

    alu_core #(
        .W (OUT_WIDTH)
    ) u_alu_core (
        .in1    (in1),
        .in2    (in2),
        .op     (op),
        .result (alu_out),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_out <= '0;
        end else if (acc_en) begin
            acc_out <= alu_out;
        end
    end

`ifdef AEOLUS_ALU_OVF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (acc_en) begin
            ovf <= alu_carry;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
    assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_aeolus_alu_datapath.sv
// tb_aeolus_alu_datapath
// Directed vectors with hand-computed results. The driver issues one vector
// per clock at the falling edge and queues the expected alu_out, acc_out and
// ovf; the monitor checks alu_out before the next rising edge and
// acc_out/ovf just after it.
module tb_aeolus_alu_datapath;

    localparam int IW = 4;
    localparam int OW = 8;

    // strobe vector order: {add, sub, and_op, or_op, xor_op, inv, clr, snza, snzs}
    localparam logic [8:0] S_NONE = 9'b0_0000_0000;
    localparam logic [8:0] S_ADD  = 9'b1_0000_0000;
    localparam logic [8:0] S_SUB  = 9'b0_1000_0000;
    localparam logic [8:0] S_AND  = 9'b0_0100_0000;
    localparam logic [8:0] S_OR   = 9'b0_0010_0000;
    localparam logic [8:0] S_XOR  = 9'b0_0001_0000;
    localparam logic [8:0] S_INV  = 9'b0_0000_1000;
    localparam logic [8:0] S_CLR  = 9'b0_0000_0100;
    localparam logic [8:0] S_SNZA = 9'b0_0000_0010;
    localparam logic [8:0] S_SNZS = 9'b0_0000_0001;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          add, sub, and_op, or_op, xor_op, inv, clr, snza, snzs, sf;
    logic [IW-1:0] a_in, b_in;
    logic [OW-1:0] shift_in;
    logic [OW-1:0] acc_out, alu_out;
    logic          ovf;

    aeolus_alu_datapath #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .add      (add),
        .sub      (sub),
        .and_op   (and_op),
        .or_op    (or_op),
        .xor_op   (xor_op),
        .inv      (inv),
        .clr      (clr),
        .snza     (snza),
        .snzs     (snzs),
        .sf       (sf),
        .a_in     (a_in),
        .b_in     (b_in),
        .shift_in (shift_in),
        .acc_out  (acc_out),
        .alu_out  (alu_out),
        .ovf      (ovf)
    );

    // scoreboard
    logic [OW-1:0] alu_q[$];
    logic [OW-1:0] exp_q[$];
    logic          ovf_q[$];
    int total = 0;
    int bad   = 0;

    // driver
    task automatic drive(input logic rst, input logic [8:0] st, input logic s_f,
                         input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input logic [OW-1:0] sh, input logic [OW-1:0] e_alu,
                         input logic [OW-1:0] e_acc, input logic e_ovf);
        @(negedge clk);
        reset    = rst;
        {add, sub, and_op, or_op, xor_op, inv, clr, snza, snzs} = st;
        sf       = s_f;
        a_in     = a;
        b_in     = b;
        shift_in = sh;
        alu_q.push_back(e_alu);
        exp_q.push_back(e_acc);
`ifdef AEOLUS_ALU_OVF_EN
        ovf_q.push_back(e_ovf);
`else
        ovf_q.push_back(1'b0);
`endif
    endtask

    // monitor
    initial begin
        logic [OW-1:0] e8;
        logic          e1;
        forever begin
            @(negedge clk);
            #2;
            if (alu_q.size() > 0) begin
                e8 = alu_q.pop_front();
                total++;
                if (alu_out !== e8) begin
                    bad++;
                    $display("FAIL alu_out t=%0t got=%h exp=%h", $time, alu_out, e8);
                end
            end
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e8 = exp_q.pop_front();
                e1 = ovf_q.pop_front();
                total++;
                if (acc_out !== e8) begin
                    bad++;
                    $display("FAIL acc_out t=%0t got=%h exp=%h", $time, acc_out, e8);
                end
                total++;
                if (ovf !== e1) begin
                    bad++;
                    $display("FAIL ovf t=%0t got=%b exp=%b", $time, ovf, e1);
                end
            end
        end
    end

    // stimulus and final report
    initial begin
        {add, sub, and_op, or_op, xor_op, inv, clr, snza, snzs} = S_NONE;
        sf = 1'b0; a_in = '0; b_in = '0; shift_in = '0;

        //    rst   strobes        sf    a      b      shift   alu     acc     ovf
        drive(1'b0, S_NONE,        1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_NONE,        1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_ADD,         1'b0, 4'hF, 4'hF, 8'h00, 8'h1E, 8'h1E, 1'b0);
        drive(1'b1, S_SUB,         1'b0, 4'h2, 4'h5, 8'h00, 8'hFD, 8'hFD, 1'b1);
        drive(1'b1, S_INV,         1'b0, 4'hF, 4'h0, 8'h00, 8'hF0, 8'hF0, 1'b0);
        drive(1'b1, S_SNZS,        1'b1, 4'h0, 4'h0, 8'h20, 8'h10, 8'h10, 1'b1);
        drive(1'b1, S_SNZS,        1'b0, 4'h0, 4'h0, 8'h20, 8'h00, 8'h10, 1'b1);
        drive(1'b1, S_ADD,         1'b0, 4'h2, 4'h3, 8'h00, 8'h05, 8'h05, 1'b0);
        drive(1'b1, S_SNZA,        1'b1, 4'h3, 4'hF, 8'h00, 8'h08, 8'h08, 1'b0);
        drive(1'b1, S_INV,         1'b0, 4'h3, 4'h0, 8'h00, 8'hFC, 8'hFC, 1'b0);
        drive(1'b1, S_CLR,         1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_SNZS,        1'b1, 4'h0, 4'h0, 8'h55, 8'h55, 8'h55, 1'b0);
        drive(1'b1, S_CLR | S_ADD, 1'b0, 4'h1, 4'h1, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_AND,         1'b0, 4'hC, 4'hA, 8'h00, 8'h08, 8'h08, 1'b0);
        drive(1'b1, S_SUB | S_AND, 1'b0, 4'h5, 4'h3, 8'h00, 8'h02, 8'h02, 1'b0);
        drive(1'b1, S_OR,          1'b0, 4'hC, 4'h3, 8'h00, 8'h0F, 8'h0F, 1'b0);
        drive(1'b1, S_XOR,         1'b0, 4'hC, 4'hA, 8'h00, 8'h06, 8'h06, 1'b0);
        drive(1'b1, S_SUB,         1'b0, 4'h0, 4'h1, 8'h00, 8'hFF, 8'hFF, 1'b1);
        drive(1'b1, S_SNZA,        1'b0, 4'h1, 4'h0, 8'h00, 8'h00, 8'hFF, 1'b1);
        drive(1'b0, S_SNZS,        1'b1, 4'h0, 4'h0, 8'h01, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_ADD,         1'b0, 4'hF, 4'h1, 8'h00, 8'h10, 8'h10, 1'b0);
        drive(1'b1, S_SNZS,        1'b1, 4'h0, 4'h0, 8'hF0, 8'h00, 8'h00, 1'b1);
        drive(1'b1, S_XOR,         1'b0, 4'h1, 4'h1, 8'h00, 8'h00, 8'h00, 1'b0);
        drive(1'b1, S_NONE,        1'b0, 4'h9, 4'h6, 8'h00, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0 || alu_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size() + alu_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog t=%0t exp=finish", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
